da_sched: RTL

DA_SCHED -- requirements
Module: da_sched

---
 rtl/da_pkg.sv | 29 ++
 rtl/da_sched_if.sv | 30 +++
 rtl/da_sched_rr_arb2.sv | 37 +++
 rtl/da_sched.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared types for the DA scheduler: sample width, FSM state encoding and
// the two-way round-robin pick used by the arbiter.
package da_pkg;

  localparam int SAMPLE_W = 10;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  // Returns the winning requester index; last_grant=1 means requester 1 was served last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic pick;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/da_sched_if.sv
// Request/acknowledge and DA-driver handshake bundle for da_sched.
interface da_sched_if
  import da_pkg::*;
();

  logic    req0;
  sample_t data0;
  logic    ack0;
  logic    req1;
  sample_t data1;
  logic    ack1;
  sample_t da_data;
  logic    send_start;
  logic    send_finish;
  logic    busy;
  logic    err;

  // scheduler side
  modport slave (
    input  req0, data0, req1, data1, send_finish,
    output ack0, ack1, da_data, send_start, busy, err
  );

  // requesters and DA driver side
  modport master (
    output req0, data0, req1, data1, send_finish,
    input  ack0, ack1, da_data, send_start, busy, err
  );

endinterface

// File: rtl/da_sched_rr_arb2.sv
// Two-way round-robin arbiter; last_grant only advances when a grant is taken.
module rr_arb2
  import da_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  logic last_grant_r;
  logic pick_s;

  // one-hot grant from the current request pattern
  always_comb begin
    pick_s = rr_pick(req, last_grant_r);
    gnt    = 2'b00;
    if (req != 2'b00) begin
      gnt = pick_s ? 2'b10 : 2'b01;
    end else begin
      gnt = 2'b00;
    end
  end

  // reset to 1 so requester 0 wins the first contested grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
    end else if (take && (req != 2'b00)) begin
      last_grant_r <= pick_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/da_sched.sv
// DA conversion scheduler: arbitrates two sample sources onto one DA driver,
// sequencing start, busy handshake, busy timeout and the inter-conversion gap.
module da_sched
  import da_pkg::*;
#(
  parameter int unsigned MIN_GAP = 8,
  parameter int unsigned BUSY_TO = 4
) (
  input logic       CLK_50M,
  input logic       RST_N,
  da_sched_if.slave bus
);

  localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP - 1);
  // the START cycle already counts toward the busy timeout
  localparam logic [7:0] TO_LAST  = (BUSY_TO > 1) ? 8'(BUSY_TO - 1) : 8'd1;

  state_t     state_r;
  state_t     state_s;
  logic       grant_s;
  logic       timeout_s;
  logic [1:0] gnt_s;
  sample_t    sel_data_s;
  logic [7:0] gap_cnt_r;
  logic [7:0] to_cnt_r;
  sample_t    da_data_r;
  logic       ack0_r;
  logic       ack1_r;
  logic       send_start_r;
  logic       busy_r;
  logic       err_r;

  rr_arb2 u_arb (
    .clk   (CLK_50M),
    .rst_n (RST_N),
    .req   ({bus.req1, bus.req0}),
    .take  (grant_s),
    .gnt   (gnt_s)
  );

  // sample of the arbitration winner
  always_comb begin
    sel_data_s = bus.data0;
    if (gnt_s[1]) begin
      sel_data_s = bus.data1;
    end else begin
      sel_data_s = bus.data0;
    end
  end

  // next-state decode, grant and timeout strobes
  always_comb begin
    state_s   = state_r;
    grant_s   = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.send_finish && (bus.req0 || bus.req1)) begin
          grant_s = 1'b1;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!bus.send_finish) begin
          state_s = ST_WAIT_DONE;
        end else if (to_cnt_r >= TO_LAST) begin
          timeout_s = 1'b1;
          state_s   = ST_GAP;
        end else begin
          state_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.send_finish) begin
          state_s = ST_GAP;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 8'd0) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // gap counter reloads on GAP entry; timeout counter restarts at each grant
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      gap_cnt_r <= 8'd0;
      to_cnt_r  <= 8'd0;
    end else begin
      if ((state_s == ST_GAP) && (state_r != ST_GAP)) begin
        gap_cnt_r <= GAP_LOAD;
      end else if ((state_r == ST_GAP) && (gap_cnt_r != 8'd0)) begin
        gap_cnt_r <= gap_cnt_r - 8'd1;
      end else begin
        gap_cnt_r <= gap_cnt_r;
      end

      if (grant_s) begin
        to_cnt_r <= 8'd0;
      end else if ((state_r == ST_START) || (state_r == ST_WAIT_BUSY)) begin
        to_cnt_r <= to_cnt_r + 8'd1;
      end else begin
        to_cnt_r <= to_cnt_r;
      end
    end
  end

  // registered outputs; ack and send_start both coincide with the START cycle
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      da_data_r    <= '0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      send_start_r <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      ack0_r       <= grant_s & gnt_s[0];
      ack1_r       <= grant_s & gnt_s[1];
      send_start_r <= grant_s;
      busy_r       <= (state_s != ST_IDLE);
      err_r        <= timeout_s;
      if (grant_s) begin
        da_data_r <= sel_data_s;
      end else begin
        da_data_r <= da_data_r;
      end
    end
  end

  assign bus.da_data    = da_data_r;
  assign bus.ack0       = ack0_r;
  assign bus.ack1       = ack1_r;
  assign bus.send_start = send_start_r;
  assign bus.busy       = busy_r;
  assign bus.err        = err_r;

endmodule
